// File: rtl/booth_mult_32.sv
// Radix-2 Booth iterative 32x32 signed multiplier with a 32-cycle latency.
// Define MULT_OVF_EN to build the signed-32-bit overflow flag on data_exception.
module booth_mult_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [64:0] p_q, p_d;
    logic [31:0] m_q, m_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        rdy_q, rdy_d;
    logic [31:0] acc;
    logic [32:0] sum;
    logic [64:0] p_step;

    // One Booth step: a 33-bit add/sub keeps the sign correct for M = -2^31.
    always_comb begin
        acc = p_q[64:33];
        case (p_q[1:0])
            2'b01:   sum = {acc[31], acc} + {m_q[31], m_q};
            2'b10:   sum = {acc[31], acc} - {m_q[31], m_q};
            default: sum = {acc[31], acc};
        endcase
        p_step = {sum, p_q[32:1]};
    end

`ifdef MULT_OVF_EN
    logic exc_q, exc_d;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rdy_d   = 1'b0;
`ifdef MULT_OVF_EN
        exc_d   = exc_q;
`endif
        if (state_q == BUSY) begin
            p_d   = p_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                state_d = IDLE;
                res_d   = p_step[32:1];
                rdy_d   = 1'b1;
`ifdef MULT_OVF_EN
                exc_d   = (p_step[64:33] != {32{p_step[32]}});
`endif
            end
        end
        // A new request overrides the step but a coincident completion stands.
        if (ctrl_MULT) begin
            state_d = BUSY;
            p_d     = {32'h0, data_operandB, 1'b0};
            m_d     = data_operandA;
            cnt_d   = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef MULT_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) exc_q <= 1'b0;
        else        exc_q <= exc_d;
    end
    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

    assign data_result    = res_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: doc/booth_mult_32.md
BOOTH_MULT_32 -- requirements
Module: booth_mult_32

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; every flop samples on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-004 The port data_operandA SHALL be an input, 32 bits wide, carrying the signed multiplicand.
REQ-005 The port data_operandB SHALL be an input, 32 bits wide, carrying the signed multiplier.
REQ-006 The port ctrl_MULT SHALL be an input, 1 bit wide, acting as the start request, sampled at the clk edge.
REQ-007 The port data_result SHALL be an output, 32 bits wide, carrying the low 32 bits of the signed product.
REQ-008 The port data_exception SHALL be an output, 1 bit wide, flagging that the product does not fit in signed 32 bits.
REQ-009 The port data_resultRDY SHALL be an output, 1 bit wide, giving a one-cycle result-valid pulse.

Function
REQ-010 The block SHALL implement a radix-2 Booth iterative multiplier with a 65-bit product register P[64:0] = {acc[31:0], mplr[31:0], q_1}, a 32-bit multiplicand latch M, a 6-bit step counter and a state in {IDLE, BUSY}.
REQ-011 When ctrl_MULT is sampled high at edge N, the block SHALL load P = {32'h0, data_operandB, 1'b0} and M = data_operandA, clear the counter and enter BUSY; operands SHALL be sampled only at this edge.
REQ-012 On each BUSY edge, the block SHALL compute a 33-bit sign-extended sum S from P[1:0]: 01 gives acc+M, 10 gives acc-M, 00/11 gives acc.
REQ-013 On each BUSY edge, the block SHALL then set P = {S[32:0], P[32:1]}, an arithmetic right shift in which the shifted-in MSB is S[32], so the product is correct for M = -2^31.
REQ-014 At edge N+32, when the 32nd step completes, the block SHALL return to IDLE, register data_result = the final P[32:1] and data_exception, and set data_resultRDY.
REQ-015 The block SHALL hold data_resultRDY high for exactly one cycle, from edge N+32 to edge N+33; the latency is 32 cycles.
REQ-016 The block SHALL hold data_result and data_exception stable until the next completion or reset.
REQ-017 The block SHALL NOT change data_result or data_exception while BUSY.
REQ-018 If ctrl_MULT is sampled high while BUSY, the current operation SHALL be aborted and restarted per REQ-011; no data_resultRDY pulse SHALL occur for the aborted operation.
REQ-019 If ctrl_MULT is sampled high at the same edge as completion (edge N+32 of the prior operation), the completion SHALL still be registered and its data_resultRDY pulse emitted, and the new operation SHALL start.
REQ-020 If ctrl_MULT is held high continuously, the block SHALL restart at every edge and SHALL never complete.

Reset
REQ-021 While reset is low, the block SHALL asynchronously force: state=IDLE, P=0, M=0, counter=0, data_result=0, data_exception=0, data_resultRDY=0.
REQ-022 A reset asserted mid-operation SHALL discard that operation; no data_resultRDY pulse SHALL follow its release.
REQ-023 After reset is released, the block SHALL ignore ctrl_MULT until the first rising edge at which reset is high.

Configuration
REQ-024 The block SHALL be configured by the macro MULT_OVF_EN.
REQ-025 With MULT_OVF_EN defined, data_exception SHALL be registered at completion as (P[64:33] != {32{P[32]}}), evaluated on the final P.
REQ-026 Without MULT_OVF_EN defined, data_exception SHALL be constant 0 and no overflow comparison logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover: A=3, B=4, ctrl_MULT at edge N -> data_resultRDY high only in cycle N+32..N+33, data_result=32'h0000000C, data_exception=0.
REQ-028 The bench SHALL cover: A=-7, B=6 -> data_result=32'hFFFFFFD6, data_exception=0.
REQ-029 The bench SHALL cover: A=32'h80000000, B=32'hFFFFFFFF -> data_result=32'h80000000, data_exception=1 with MULT_OVF_EN and 0 without it.
REQ-030 The bench SHALL cover: A=32'h00010000, B=32'h00010000 -> data_result=0, data_exception=1 with MULT_OVF_EN.
REQ-031 The bench SHALL cover: start 5x5 at edge N, then start 2x3 at edge N+10 -> no data_resultRDY at N+32, single data_resultRDY at N+42 with data_result=6.
REQ-032 The bench SHALL cover: start 9x9, pull reset low at edge N+15 for 2 cycles -> all outputs 0 immediately, and no data_resultRDY pulse ever for that operation.
